// File: rtl/calc_sequencer.sv
// calc_sequencer: debounced enter/clear front end that sequences operand entry, ALU execution and result display.
// Optional feature macro: CALC_CHAIN_EN (enter in S_SHOW chains the result low nibble into operand A).
module calc_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RESULT_W        = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_enter,
    input  logic                btn_clear,
    input  logic [3:0]          sw_data,
    input  logic                sw_op,
    input  logic                sw_sign,
    input  logic [RESULT_W-1:0] alu_result,
    output logic [3:0]          op1,
    output logic [3:0]          op2,
    output logic                operation,
    output logic                sign,
    output logic [RESULT_W-1:0] disp_value,
    output logic [2:0]          state,
    output logic                busy
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A       = 3'd0,
        S_B       = 3'd1,
        S_EXEC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          op1_q, op1_d, op2_q, op2_d;
    logic                operation_q, operation_d, sign_q, sign_d;
    logic [RESULT_W-1:0] disp_q, disp_d;
    // bit 0 = enter, bit 1 = clear
    logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]          stable_q, stable_d, prev_q, prev_d;
    logic [CW-1:0]       cnt_q [2];
    logic [CW-1:0]       cnt_d [2];
    logic [1:0]          press;
    logic                enter_ev, clear_ev;

    // Synchronize both buttons and accept a new level only after it has been stable long enough
    always_comb begin
        sync1_d  = {btn_clear, btn_enter};
        sync2_d  = sync1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press = stable_q & ~prev_q;
    end

    assign enter_ev = press[0];
    assign clear_ev = press[1];

    // Next state and register updates; clear overrides everything including a same-cycle enter
    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        operation_d = operation_q;
        sign_d      = sign_q;
        disp_d      = disp_q;
        if (clear_ev) begin
            state_d     = S_A;
            op1_d       = '0;
            op2_d       = '0;
            operation_d = 1'b0;
            sign_d      = 1'b0;
            disp_d      = '0;
        end else begin
            case (state_q)
                S_A: begin
                    disp_d = RESULT_W'(sw_data);
                    if (enter_ev) begin
                        op1_d   = sw_data;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    disp_d = RESULT_W'(sw_data);
                    if (enter_ev) begin
                        op2_d       = sw_data;
                        operation_d = sw_op;
                        sign_d      = sw_sign;
                        state_d     = S_EXEC;
                    end
                end
                S_EXEC: state_d = S_CAPTURE;
                S_CAPTURE: begin
                    disp_d  = alu_result;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (enter_ev) begin
`ifdef CALC_CHAIN_EN
                        op1_d   = alu_result[3:0];
                        state_d = S_B;
`else
                        op1_d       = '0;
                        op2_d       = '0;
                        operation_d = 1'b0;
                        sign_d      = 1'b0;
                        state_d     = S_A;
`endif
                    end
                end
                default: begin
                    state_d     = S_A;
                    op1_d       = '0;
                    op2_d       = '0;
                    operation_d = 1'b0;
                    sign_d      = 1'b0;
                    disp_d      = '0;
                end
            endcase
        end
    end

    // State, datapath and button conditioning registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_A;
            op1_q       <= '0;
            op2_q       <= '0;
            operation_q <= 1'b0;
            sign_q      <= 1'b0;
            disp_q      <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            prev_q      <= '0;
            cnt_q       <= '{'0, '0};
        end else begin
            state_q     <= state_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            operation_q <= operation_d;
            sign_q      <= sign_d;
            disp_q      <= disp_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign op1        = op1_q;
    assign op2        = op2_q;
    assign operation  = operation_q;
    assign sign       = sign_q;
    assign disp_value = disp_q;
    assign state      = state_q;
    assign busy       = (state_q == S_EXEC) || (state_q == S_CAPTURE);
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed checks of calc_sequencer with a small add/multiply ALU model.
module tb_calc_sequencer;
    localparam int RW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          btn_enter = 1'b0;
    logic          btn_clear = 1'b0;
    logic [3:0]    sw_data = 4'd0;
    logic          sw_op = 1'b0;
    logic          sw_sign = 1'b0;
    logic [RW-1:0] alu_result;
    logic [3:0]    op1, op2;
    logic          operation, sign, busy;
    logic [RW-1:0] disp_value;
    logic [2:0]    state;

    int            n_total = 0;
    int            n_pass = 0;
    int            chg = 0;
    logic [2:0]    last = 3'd0;

    calc_sequencer #(.DEBOUNCE_CYCLES(4), .RESULT_W(RW)) dut (
        .clk(clk), .reset(reset), .btn_enter(btn_enter), .btn_clear(btn_clear),
        .sw_data(sw_data), .sw_op(sw_op), .sw_sign(sw_sign), .alu_result(alu_result),
        .op1(op1), .op2(op2), .operation(operation), .sign(sign),
        .disp_value(disp_value), .state(state), .busy(busy)
    );

    assign alu_result = operation ? RW'(op1) * RW'(op2) : RW'(op1) + RW'(op2);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        tick(8);
        btn_enter = 1'b0;
        tick(8);
    endtask

    task automatic drive_enter(input logic v, input int n);
        btn_enter = v;
        repeat (n) begin
            @(negedge clk);
            if (state !== last) chg++;
            last = state;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    initial begin
        // reset held for 3 cycles
        tick(3);
        check("rst_state", 32'(state), 0);
        check("rst_op1", 32'(op1), 0);
        check("rst_op2", 32'(op2), 0);
        check("rst_disp", 32'(disp_value), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick(2);

        // bounced enter yields exactly one press
        last = state;
        chg  = 0;
        drive_enter(1'b1, 2);
        drive_enter(1'b0, 2);
        drive_enter(1'b1, 2);
        drive_enter(1'b0, 2);
        drive_enter(1'b1, 10);
        drive_enter(1'b0, 10);
        check("bounce_changes", 32'(chg), 1);
        check("bounce_state", 32'(state), 1);

        // 5 + 3 with exact execute timing
        do_reset();
        sw_data = 4'd5;
        press_enter();
        check("a_state", 32'(state), 1);
        check("a_op1", 32'(op1), 5);
        sw_data   = 4'd3;
        sw_op     = 1'b0;
        btn_enter = 1'b1;
        wait_state(3'd2, "exec_state");
        check("exec_busy", 32'(busy), 1);
        tick(1);
        check("cap_state", 32'(state), 3);
        check("cap_busy", 32'(busy), 1);
        check("cap_disp_preview", 32'(disp_value), 3);
        tick(1);
        check("show_state", 32'(state), 4);
        check("show_disp", 32'(disp_value), 8);
        check("show_busy", 32'(busy), 0);
        check("show_op1", 32'(op1), 5);
        check("show_op2", 32'(op2), 3);
        btn_enter = 1'b0;
        tick(10);
        sw_data = 4'd15;
        tick(3);
        check("show_hold_disp", 32'(disp_value), 8);
        check("show_hold_state", 32'(state), 4);
        press_enter();
`ifdef CALC_CHAIN_EN
        check("show_enter_state", 32'(state), 1);
        check("show_enter_op1", 32'(op1), 8);
        check("show_enter_op2", 32'(op2), 3);
`else
        check("show_enter_state", 32'(state), 0);
        check("show_enter_op1", 32'(op1), 0);
        check("show_enter_op2", 32'(op2), 0);
`endif

        // clear lands in S_EXEC, result never captured
        do_reset();
        sw_data = 4'd6;
        press_enter();
        sw_data   = 4'd7;
        btn_enter = 1'b1;
        tick(1);
        btn_clear = 1'b1;
        wait_state(3'd2, "clr_exec_state");
        tick(1);
        check("clr_state", 32'(state), 0);
        check("clr_disp", 32'(disp_value), 0);
        check("clr_op1", 32'(op1), 0);
        check("clr_op2", 32'(op2), 0);
        check("clr_busy", 32'(busy), 0);
        tick(1);
        check("clr_preview", 32'(disp_value), 7);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick(10);
        check("clr_release_state", 32'(state), 0);

        // enter and clear on the same cycle in S_B
        do_reset();
        sw_data = 4'd4;
        press_enter();
        check("both_pre_state", 32'(state), 1);
        sw_data   = 4'd9;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        tick(10);
        check("both_state", 32'(state), 0);
        check("both_op2", 32'(op2), 0);
        check("both_op1", 32'(op1), 0);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick(10);
        check("both_release_state", 32'(state), 0);

`ifdef CALC_CHAIN_EN
        // chained calculation 7*3 then 5+2
        do_reset();
        sw_data = 4'd7;
        press_enter();
        sw_data = 4'd3;
        sw_op   = 1'b1;
        press_enter();
        check("chain_show_state", 32'(state), 4);
        check("chain_mul_disp", 32'(disp_value), 21);
        press_enter();
        check("chain_b_state", 32'(state), 1);
        check("chain_op1", 32'(op1), 5);
        sw_data = 4'd2;
        sw_op   = 1'b0;
        press_enter();
        check("chain_add_state", 32'(state), 4);
        check("chain_add_disp", 32'(disp_value), 7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Front-end controller for the 4-bit mini ALU and the 4-digit seven-segment display path.
- Debounces two push buttons (enter, clear) and walks the user through operand A entry, then operand B/operation entry, then execution.
- Drives the ALU operand/control inputs from registers and latches the ALU result into a held display value.
- Sits between the board switches/buttons and the ALU/display encoder inside the calculator top level.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized cycles required before a button level is accepted; legal range >= 2.
- RESULT_W, 20: width of the ALU result bus and of disp_value.

Ports:
- clk  input  1  system clock; all registers use its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_enter  input  1  raw enter button, asynchronous to clk, active-high.
- btn_clear  input  1  raw clear button, asynchronous to clk, active-high.
- sw_data  input  4  operand switches.
- sw_op  input  1  operation select switch.
- sw_sign  input  1  signed/unsigned select switch.
- alu_result  input  RESULT_W  combinational ALU result for the current op1/op2/operation/sign.
- op1  output  4  registered operand A to the ALU.
- op2  output  4  registered operand B to the ALU.
- operation  output  1  registered operation select to the ALU.
- sign  output  1  registered sign mode to the ALU.
- disp_value  output  RESULT_W  registered value for the display encoder.
- state  output  3  current FSM state encoding, for debug LEDs.
- busy  output  1  high in S_EXEC and S_CAPTURE.

Behaviour:
- Reset values (async, reset high):
  - state = S_A; op1 = op2 = 0; operation = sign = 0.
  - disp_value = 0; busy = 0.
  - Debounce counters = 0; stable levels = 0; synchronizers = 0.
- Button conditioning, per button, independent:
  - 2-FF synchronizer feeds a debounce counter.
  - Counter clears whenever the sync level equals the stable level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the levels still differ, the stable level takes the sync level and the counter clears.
  - Press event = one-cycle pulse on the 0->1 transition of the stable level.
  - Release produces no event. Holding a button produces exactly one event.
- Latency: raw edge -> press event = 2 sync cycles + DEBOUNCE_CYCLES, with the event visible on the following cycle.
- State encoding: S_A=0, S_B=1, S_EXEC=2, S_CAPTURE=3, S_SHOW=4. Codes 5-7 are illegal and return to S_A on the next clock with all registers cleared as on reset.
- S_A:
  - disp_value <= zero-extended sw_data every cycle (live preview).
  - On enter: op1 <= sw_data, go to S_B.
- S_B:
  - disp_value <= zero-extended sw_data every cycle.
  - On enter: op2 <= sw_data, operation <= sw_op, sign <= sw_sign, go to S_EXEC.
- S_EXEC: one settle cycle, ignores enter, then goes to S_CAPTURE.
- S_CAPTURE: disp_value <= alu_result, then goes to S_SHOW.
- Enter-to-display latency from S_B: disp_value updates 3 clocks after the press-event cycle.
- S_SHOW:
  - disp_value holds; switch changes have no effect.
  - On enter: op1 = op2 = 0, operation = sign = 0, go to S_A.
- Clear (any state, including S_EXEC and S_CAPTURE): next state = S_A; op1 = op2 = 0; operation = sign = 0; disp_value = 0.
- Clear and enter events in the same cycle: clear wins and enter is dropped.
- Reset asserted mid-sequence: immediate return to reset values. After reset releases, debounce restarts from stable = 0, so a button already held during reset produces one press event after debounce.
- No other input affects state.

Optional Feature:
- CALC_CHAIN_EN defined:
  - Enter in S_SHOW sets op1 <= alu_result[3:0] and goes directly to S_B; op2, operation and sign are kept until the next S_B capture.
  - disp_value keeps showing the previous result until the first S_B cycle, then previews sw_data.
- Not defined: S_SHOW behaviour exactly as in Behaviour.

Test Plan:
Bench settings: DEBOUNCE_CYCLES=4; ALU model returns op1+op2 when operation=0 and op1*op2 when operation=1, zero-extended.
1. Reset, then hold reset for 3 cycles -> state=0, op1=0, op2=0, disp_value=0, busy=0.
2. sw_data=5, enter; sw_data=3, sw_op=0, enter -> op1=5, op2=3, busy high for 2 cycles, disp_value=8 three clocks after the second press event, state=4.
3. Bounce btn_enter 1-0-1-0-1 with 2-cycle pulses, then hold 10 cycles -> exactly one press event, state moves 0->1 only.
4. Clear pressed while state=2 -> next state=0, op1=op2=0, disp_value=0; the ALU result is never captured.
5. Enter and clear stable-rise on the same cycle in S_B -> state=0, op2 unchanged at 0.
6. CALC_CHAIN_EN: 7*3 gives disp_value=21; enter -> op1=5 (21 mod 16), state=1; sw_data=2, sw_op=0, enter -> disp_value=7.
